// File: rtl/hyperbus_resp.sv
// hyperbus_resp: HyperBus device-side responder (CA decode, latency, burst R/W, ID0/CR0 registers).
// Latency: the 3-beat CA is followed by Leff latency cycles; read data is registered, one beat per clk_i.
// Backpressure: none; the host paces the burst with hb_cs_n_i, and a high CS aborts in any state.
// Optional feature macro: HYPERBUS_RESP_REGSPACE_EN enables the writable CR0 and readable ID0.
// Ports: clk_i/rst_i (sync, active-high); hb_cs_n_i, hb_dq_i, hb_rwds_i (write byte mask, 1 = masked);
//        hb_dq_o/hb_dq_oe_o (read data), hb_rwds_o/hb_rwds_oe_o (latency flag / read strobe), busy_o.
module hyperbus_resp #(
  parameter int          AddrWidth      = 16,
  parameter int          DefaultLatency = 6,
  parameter logic [15:0] IdValue        = 16'h0C81
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hb_cs_n_i,
  input  logic [15:0] hb_dq_i,
  input  logic [1:0]  hb_rwds_i,
  output logic [15:0] hb_dq_o,
  output logic        hb_dq_oe_o,
  output logic        hb_rwds_o,
  output logic        hb_rwds_oe_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CA, S_LATENCY, S_READ, S_WRITE, S_REG_WRITE, S_HOLD
  } state_t;

  localparam logic [3:0] DefLat   = 4'(DefaultLatency);
  localparam logic [7:0] Cr0Reset = {DefLat, 4'b1111};

  state_t                 state_q, state_d;
  logic [31:0]            ca_hi_q;
  logic                   ca_idx_q;
  logic [4:0]             lat_cnt_q;
  logic [AddrWidth-1:0]   addr_q, addr_next, wrap_mask_q, wrap_mask_d;
  logic                   linear_q, is_reg_q, is_write_q;
  logic [15:0]            dq_q;
  logic                   dq_oe_q;
  logic [7:0]             cr0;
  logic [15:0]            reg_rdata;
  logic [47:0]            ca_full;
  logic [31:0]            word_addr_full;
  logic [4:0]             leff;
  logic                   ca_reg_wr, rd_issue, wr_en, unused_ok;

  logic [15:0] mem [0:(1 << AddrWidth) - 1];

  // The last CA word is decoded straight off the bus on beat 2.
  assign ca_full        = {ca_hi_q, hb_dq_i};
  assign word_addr_full = {ca_full[44:16], ca_full[2:0]};
  assign leff           = cr0[3] ? {cr0[7:4], 1'b0} : {1'b0, cr0[7:4]};

  always_comb begin
    wrap_mask_d = AddrWidth'(6'h3F);
    case (cr0[1:0])
      2'b01:   wrap_mask_d = AddrWidth'(6'h1F);
      2'b10:   wrap_mask_d = AddrWidth'(6'h07);
      2'b11:   wrap_mask_d = AddrWidth'(6'h0F);
      default: wrap_mask_d = AddrWidth'(6'h3F);
    endcase
  end

  // Wrapped bursts only advance the bits inside the wrap window.
  assign addr_next = linear_q ? addr_q + AddrWidth'(1)
                              : (addr_q & ~wrap_mask_q) | ((addr_q + AddrWidth'(1)) & wrap_mask_q);

  // A read beat is fetched one cycle ahead so hb_dq_o can be a plain register.
  assign rd_issue = !hb_cs_n_i && !rst_i &&
                    ((state_q == S_LATENCY && lat_cnt_q == 5'd0 && !is_write_q) || state_q == S_READ);
  assign wr_en    = !hb_cs_n_i && !rst_i && state_q == S_WRITE && !is_reg_q;

`ifdef HYPERBUS_RESP_REGSPACE_EN
  logic [7:0] cr0_q;
  assign ca_reg_wr = ca_full[47] & ca_full[46];
  assign cr0       = cr0_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cr0_q <= Cr0Reset;
    end else if (!hb_cs_n_i && state_q == S_REG_WRITE && addr_q == AddrWidth'(1)) begin
      cr0_q <= hb_dq_i[7:0];
    end
  end

  always_comb begin
    reg_rdata = 16'h0000;
    if (addr_q == '0)                 reg_rdata = IdValue;
    else if (addr_q == AddrWidth'(1)) reg_rdata = {8'h8F, cr0};
  end
`else
  // Without the register space, space-1 accesses take the memory path and carry no data.
  assign ca_reg_wr = 1'b0;
  assign cr0       = Cr0Reset;
  assign reg_rdata = 16'h0000;
`endif

  assign unused_ok = ^{ca_full, word_addr_full, cr0, IdValue};

  always_comb begin
    state_d = state_q;
    if (hb_cs_n_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_CA;
        S_CA:        if (ca_idx_q) state_d = ca_reg_wr ? S_REG_WRITE : S_LATENCY;
        S_LATENCY:   if (lat_cnt_q == 5'd0) state_d = is_write_q ? S_WRITE : S_READ;
        S_REG_WRITE: state_d = S_HOLD;
        default:     state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ca_hi_q     <= '0;
      ca_idx_q    <= 1'b0;
      lat_cnt_q   <= '0;
      addr_q      <= '0;
      wrap_mask_q <= '0;
      linear_q    <= 1'b0;
      is_reg_q    <= 1'b0;
      is_write_q  <= 1'b0;
      dq_q        <= '0;
      dq_oe_q     <= 1'b0;
    end else begin
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      if (!hb_cs_n_i) begin
        case (state_q)
          S_IDLE: begin
            ca_hi_q[31:16] <= hb_dq_i;
            ca_idx_q       <= 1'b0;
          end
          S_CA: begin
            if (!ca_idx_q) begin
              ca_hi_q[15:0] <= hb_dq_i;
              ca_idx_q      <= 1'b1;
            end else begin
              addr_q      <= word_addr_full[AddrWidth-1:0];
              is_write_q  <= ca_full[47];
              is_reg_q    <= ca_full[46];
              linear_q    <= ca_full[45];
              wrap_mask_q <= wrap_mask_d;
              lat_cnt_q   <= (leff == 5'd0) ? 5'd0 : leff - 5'd1;
            end
          end
          S_LATENCY: if (lat_cnt_q != 5'd0) lat_cnt_q <= lat_cnt_q - 5'd1;
          default: ;
        endcase
        if (rd_issue) begin
          dq_q    <= is_reg_q ? reg_rdata : mem[addr_q];
          dq_oe_q <= 1'b1;
        end
        // Register accesses keep pointing at the same register.
        if ((rd_issue || wr_en) && !is_reg_q) addr_q <= addr_next;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      if (!hb_rwds_i[1]) mem[addr_q][15:8] <= hb_dq_i[15:8];
      if (!hb_rwds_i[0]) mem[addr_q][7:0]  <= hb_dq_i[7:0];
    end
  end

  assign hb_dq_o      = dq_q;
  assign hb_dq_oe_o   = dq_oe_q;
  assign hb_rwds_oe_o = (state_q == S_CA) | dq_oe_q;
  assign hb_rwds_o    = ((state_q == S_CA) & cr0[3]) | dq_oe_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_hyperbus_resp.sv
// tb_hyperbus_resp: directed transaction table plus hand-written abort/reset/register sequences.
// Latency: expected data beats at c(3+Leff+k), with Leff tracked by the bench from the CR0 it wrote.
// Backpressure: n/a; the bench drives CS, CA and write beats on fixed cycles.
module tb_hyperbus_resp;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        hb_cs_n_i = 1'b1;
  logic [15:0] hb_dq_i = 16'h0000;
  logic [1:0]  hb_rwds_i = 2'b00;
  logic [15:0] hb_dq_o;
  logic        hb_dq_oe_o, hb_rwds_o, hb_rwds_oe_o, busy_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_leff = 12;
  logic cur_rwds = 1'b1;

  typedef struct packed {
    logic             wr;
    logic             rs;
    logic             lin;
    logic [31:0]      addr;
    logic [3:0]       nb;
    logic [7:0][15:0] wd;
    logic [7:0][1:0]  msk;
    logic [7:0][15:0] exp_dat;
  } txn_t;

  txn_t vec_a[$];
  txn_t vec_b[$];

  always #5 clk_i = ~clk_i;

  hyperbus_resp #(.AddrWidth(16), .DefaultLatency(6), .IdValue(16'h0C81)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hb_cs_n_i(hb_cs_n_i), .hb_dq_i(hb_dq_i), .hb_rwds_i(hb_rwds_i),
    .hb_dq_o(hb_dq_o), .hb_dq_oe_o(hb_dq_oe_o), .hb_rwds_o(hb_rwds_o),
    .hb_rwds_oe_o(hb_rwds_oe_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  function automatic logic [127:0] w4(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c, input logic [15:0] d);
    return {64'h0, d, c, b, a};
  endfunction

  function automatic txn_t mk(input logic wr, input logic rs, input logic lin, input logic [31:0] addr,
                              input int nb, input logic [127:0] d, input logic [15:0] msk);
    txn_t t;
    t.wr = wr; t.rs = rs; t.lin = lin; t.addr = addr; t.nb = 4'(nb); t.msk = msk;
    t.wd      = wr ? d : '0;
    t.exp_dat = wr ? '0 : d;
    return t;
  endfunction

  function automatic logic [47:0] make_ca(input logic wr, input logic rs, input logic lin,
                                          input logic [31:0] addr);
    return {wr, rs, lin, addr[31:3], 13'h0, addr[2:0]};
  endfunction

  task automatic send_ca(input logic wr, input logic rs, input logic lin, input logic [31:0] addr,
                         input logic exp_rwds);
    logic [47:0] ca;
    ca = make_ca(wr, rs, lin, addr);
    for (int i = 0; i < 3; i++) begin
      step();
      hb_cs_n_i = 1'b0;
      hb_dq_i   = ca[47 - 16*i -: 16];
      hb_rwds_i = 2'b00;
      sample();
      if (i == 0) begin
        check("ca0_busy", busy_o, 0);
        check("ca0_rwds_oe", hb_rwds_oe_o, 0);
      end else begin
        check("ca_rwds_oe", hb_rwds_oe_o, 1);
        check("ca_rwds", hb_rwds_o, exp_rwds);
        check("ca_busy", busy_o, 1);
      end
    end
  endtask

  task automatic wait_latency(input int leff);
    for (int i = 0; i < leff; i++) begin
      step();
      hb_dq_i = 16'h0000;
      sample();
      check("lat_dq_oe", hb_dq_oe_o, 0);
    end
  endtask

  task automatic end_txn();
    step();
    hb_cs_n_i = 1'b1;
    hb_dq_i   = 16'h0000;
    hb_rwds_i = 2'b00;
    step();
    sample();
    check("end_busy", busy_o, 0);
    check("end_dq_oe", hb_dq_oe_o, 0);
    check("end_dq", hb_dq_o, 0);
  endtask

  task automatic do_txn(input txn_t t, input int leff, input logic exp_rwds);
    send_ca(t.wr, t.rs, t.lin, t.addr, exp_rwds);
    wait_latency(leff);
    for (int k = 0; k < int'(t.nb); k++) begin
      step();
      if (t.wr) begin
        hb_dq_i   = t.wd[k];
        hb_rwds_i = t.msk[k];
      end else begin
        hb_dq_i   = 16'h0000;
      end
      sample();
      if (!t.wr) begin
        check("rd_dq_oe", hb_dq_oe_o, 1);
        check("rd_rwds", hb_rwds_o, 1);
        check($sformatf("rd_dat@%0h+%0d", t.addr, k), hb_dq_o, t.exp_dat[k]);
      end else begin
        check("wr_dq_oe", hb_dq_oe_o, 0);
      end
    end
    end_txn();
  endtask

  initial begin
    // Default CR0: Leff = 2*6 = 12, rwds high during CA, 16-word wrap.
    vec_a.push_back(mk(1, 0, 1, 32'h0010, 4, w4(16'h1111, 16'h2222, 16'h3333, 16'h4444), 16'h0));
    vec_a.push_back(mk(0, 0, 1, 32'h0010, 4, w4(16'h1111, 16'h2222, 16'h3333, 16'h4444), 16'h0));
    vec_a.push_back(mk(1, 0, 1, 32'h0100, 1, w4(16'h1234, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(1, 0, 1, 32'h0100, 1, w4(16'hABCD, 0, 0, 0), 16'h0002));
    vec_a.push_back(mk(0, 0, 1, 32'h0100, 1, w4(16'h12CD, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(1, 0, 1, 32'h0020, 2, w4(16'hA020, 16'hA021, 0, 0), 16'h0));
    vec_a.push_back(mk(1, 0, 1, 32'h002E, 2, w4(16'hA02E, 16'hA02F, 0, 0), 16'h0));
    vec_a.push_back(mk(0, 0, 0, 32'h002E, 4, w4(16'hA02E, 16'hA02F, 16'hA020, 16'hA021), 16'h0));
    vec_a.push_back(mk(1, 0, 0, 32'h004F, 2, w4(16'hB04F, 16'hB040, 0, 0), 16'h0));
    vec_a.push_back(mk(0, 0, 1, 32'h0040, 1, w4(16'hB040, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(0, 0, 1, 32'h004F, 1, w4(16'hB04F, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(1, 0, 1, 32'h0001_0005, 1, w4(16'h5005, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(0, 0, 1, 32'h0005, 1, w4(16'h5005, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(1, 0, 1, 32'hFFFF, 2, w4(16'hF0FF, 16'hF000, 0, 0), 16'h0));
    vec_a.push_back(mk(0, 0, 1, 32'h0000, 1, w4(16'hF000, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(0, 0, 1, 32'hFFFF, 1, w4(16'hF0FF, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(1, 0, 1, 32'h0200, 4, w4(16'h5550, 16'h5551, 16'h5552, 16'h5553), 16'h0));
`ifdef HYPERBUS_RESP_REGSPACE_EN
    vec_a.push_back(mk(0, 1, 1, 32'h0000, 2, w4(16'h0C81, 16'h0C81, 0, 0), 16'h0));
    vec_a.push_back(mk(0, 1, 1, 32'h0001, 1, w4(16'h8F6F, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(0, 1, 1, 32'h0005, 1, w4(16'h0000, 0, 0, 0), 16'h0));
    // After CR0 <= 0x32: Leff 3, rwds low during CA, 8-word wrap.
    vec_b.push_back(mk(0, 0, 1, 32'h0010, 1, w4(16'h1111, 0, 0, 0), 16'h0));
    vec_b.push_back(mk(1, 0, 1, 32'h0000, 8,
                       {16'hC007, 16'hC006, 16'hC005, 16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000}, 16'h0));
    vec_b.push_back(mk(0, 0, 0, 32'h0006, 4, w4(16'hC006, 16'hC007, 16'hC000, 16'hC001), 16'h0));
    vec_b.push_back(mk(0, 1, 1, 32'h0001, 1, w4(16'h8F32, 0, 0, 0), 16'h0));
    vec_b.push_back(mk(0, 1, 1, 32'h0000, 1, w4(16'h0C81, 0, 0, 0), 16'h0));
`else
    vec_a.push_back(mk(0, 1, 1, 32'h0000, 2, w4(16'h0000, 16'h0000, 0, 0), 16'h0));
    vec_a.push_back(mk(0, 1, 1, 32'h0001, 1, w4(16'h0000, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(1, 1, 1, 32'h0010, 1, w4(16'hDEAD, 0, 0, 0), 16'h0));
    vec_a.push_back(mk(0, 0, 1, 32'h0010, 1, w4(16'h1111, 0, 0, 0), 16'h0));
`endif

    // Reset state
    step(); step(); step();
    sample();
    check("rst_dq_oe", hb_dq_oe_o, 0);
    check("rst_dq", hb_dq_o, 0);
    check("rst_rwds_oe", hb_rwds_oe_o, 0);
    check("rst_rwds", hb_rwds_o, 0);
    check("rst_busy", busy_o, 0);
    step();
    rst_i = 1'b0;
    step();
    sample();
    check("post_rst_busy", busy_o, 0);

    for (int i = 0; i < vec_a.size(); i++) do_txn(vec_a[i], cur_leff, cur_rwds);

    // Abort after 2 of 4 write beats; the beat coinciding with CS rise must not land.
    send_ca(1, 0, 1, 32'h0200, cur_rwds);
    wait_latency(cur_leff);
    step(); hb_dq_i = 16'hE000;
    step(); hb_dq_i = 16'hE001;
    step(); hb_cs_n_i = 1'b1; hb_dq_i = 16'hE002;
    sample();
    check("abort_busy_edge", busy_o, 1);
    step(); hb_dq_i = 16'h0000;
    sample();
    check("abort_busy_idle", busy_o, 0);
    do_txn(mk(0, 0, 1, 32'h0200, 4, w4(16'hE000, 16'hE001, 16'h5552, 16'h5553), 16'h0), cur_leff, cur_rwds);

`ifdef HYPERBUS_RESP_REGSPACE_EN
    // CR0 write: data at c3, Hold at c4, Idle at c5; upper byte is ignored.
    send_ca(1, 1, 1, 32'h0001, cur_rwds);
    step(); hb_dq_i = 16'hA532;
    sample();
    check("regwr_busy", busy_o, 1);
    check("regwr_dq_oe", hb_dq_oe_o, 0);
    step(); hb_cs_n_i = 1'b1; hb_dq_i = 16'h0000;
    sample();
    check("regwr_hold_busy", busy_o, 1);
    step();
    sample();
    check("regwr_idle_busy", busy_o, 0);
    cur_leff = 3;
    cur_rwds = 1'b0;
    // ID0 write attempt is discarded.
    send_ca(1, 1, 1, 32'h0000, cur_rwds);
    step(); hb_dq_i = 16'hFFFF;
    step(); hb_cs_n_i = 1'b1; hb_dq_i = 16'h0000;
    step();
    for (int i = 0; i < vec_b.size(); i++) do_txn(vec_b[i], cur_leff, cur_rwds);
`endif

    // Reset in the middle of a read burst.
    send_ca(0, 0, 1, 32'h0010, cur_rwds);
    wait_latency(cur_leff);
    step();
    sample();
    check("mid_rd0", hb_dq_o, 16'h1111);
    step(); rst_i = 1'b1;
    sample();
    check("mid_rd1", hb_dq_o, 16'h2222);
    step(); rst_i = 1'b0; hb_cs_n_i = 1'b1;
    sample();
    check("midrst_dq_oe", hb_dq_oe_o, 0);
    check("midrst_dq", hb_dq_o, 0);
    check("midrst_rwds_oe", hb_rwds_oe_o, 0);
    check("midrst_rwds", hb_rwds_o, 0);
    check("midrst_busy", busy_o, 0);
    cur_leff = 12;
    cur_rwds = 1'b1;
`ifdef HYPERBUS_RESP_REGSPACE_EN
    do_txn(mk(0, 1, 1, 32'h0001, 1, w4(16'h8F6F, 0, 0, 0), 16'h0), cur_leff, cur_rwds);
`endif
    do_txn(mk(0, 0, 1, 32'h0010, 4, w4(16'h1111, 16'h2222, 16'h3333, 16'h4444), 16'h0), cur_leff, cur_rwds);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
